// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back, write-allocate data cache.
// All tags, lines and status bits live in flops. The memory side transfers
// whole lines. A flush walks every (set, way) entry in order and writes back
// each dirty line.
//
// state      | meaning
// IDLE       | serve hits, launch miss handling or a pending flush
// MISS       | choose and latch the victim, issue writeback or refill read
// WRITEBACK  | dirty victim line being written to memory
// READMISS   | refill read outstanding, line written into victim on ack
// REFILL     | one settling cycle, then the request hits in IDLE
// FLUSH_SCAN | examine one entry per cycle for valid & dirty
// FLUSH_WB   | dirty entry being written back during flush
module dcache_assoc #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int INDEX_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int WORD_W   = OFFSET_W - 2;

    typedef enum logic [2:0] {
        IDLE, MISS, WRITEBACK, READMISS, REFILL, FLUSH_SCAN, FLUSH_WB
    } state_t;

    state_t                  r_state;
    logic [1:0][SETS-1:0]    r_valid;
    logic [1:0][SETS-1:0]    r_dirty;
    logic [SETS-1:0]         r_lru;
    logic [TAG_W-1:0]        r_tag  [0:1][0:SETS-1];
    logic [LINE_W-1:0]       r_line [0:1][0:SETS-1];
    logic                    r_victim;
    logic                    r_flush_pend;
    logic [INDEX_W:0]        r_scan;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [WORD_W-1:0]  w_word;
    logic               w_req, w_hit0, w_hit1, w_hit, w_hit_way, w_vict_sel;
    logic               w_wr_hit, w_refill;
    logic [INDEX_W-1:0] w_sc_set;
    logic               w_sc_way, w_sc_last;
    logic               w_unused_ok;

    assign w_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_index   = p1_addr_i[OFFSET_W +: INDEX_W];
    assign w_word    = p1_addr_i[2 +: WORD_W];
    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit0    = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit1    = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = ~w_hit0;
    // first invalid way wins, way0 before way1; otherwise the LRU way
    assign w_vict_sel = !r_valid[0][w_index] ? 1'b0 :
                        !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
    assign w_wr_hit  = (r_state == IDLE) && p1_MemWrite_i && w_hit;
    assign w_refill  = (r_state == READMISS) && mem_ack_i;
    assign w_sc_set  = r_scan[INDEX_W:1];
    assign w_sc_way  = r_scan[0];
    assign w_sc_last = &r_scan;
    // byte-offset bits below word granularity are never used
    assign w_unused_ok = &{1'b0, p1_addr_i[1:0]};

    assign p1_stall_o = w_req & (~w_hit | (r_state != IDLE));
    assign p1_data_o  = w_hit ? r_line[w_hit_way][w_index][{w_word, 5'b0} +: 32] : 32'h0;

    // controller FSM, status bits and registered memory-side outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_lru        <= '0;
            r_victim     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_scan       <= '0;
            flush_done_o <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            flush_done_o <= 1'b0;
            if (flush_i) r_flush_pend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        r_lru[w_index] <= ~w_hit_way;
                        if (p1_MemWrite_i) r_dirty[w_hit_way][w_index] <= 1'b1;
                    end
                    if (w_req && !w_hit) r_state <= MISS;
                    else if (r_flush_pend) r_state <= FLUSH_SCAN;
                end
                MISS: begin
                    r_victim     <= w_vict_sel;
                    mem_enable_o <= 1'b1;
                    if (r_valid[w_vict_sel][w_index] && r_dirty[w_vict_sel][w_index]) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {r_tag[w_vict_sel][w_index], w_index, {OFFSET_W{1'b0}}};
                        mem_data_o  <= r_line[w_vict_sel][w_index];
                        r_state     <= WRITEBACK;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_state     <= READMISS;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_state     <= READMISS;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        r_valid[r_victim][w_index] <= 1'b1;
                        r_dirty[r_victim][w_index] <= 1'b0;
                        r_lru[w_index]             <= ~r_victim;
                        mem_enable_o               <= 1'b0;
                        r_state                    <= REFILL;
                    end
                end
                REFILL: r_state <= IDLE;
                FLUSH_SCAN: begin
                    if (r_valid[w_sc_way][w_sc_set] && r_dirty[w_sc_way][w_sc_set]) begin
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= 1'b1;
                        mem_addr_o   <= {r_tag[w_sc_way][w_sc_set], w_sc_set, {OFFSET_W{1'b0}}};
                        mem_data_o   <= r_line[w_sc_way][w_sc_set];
                        r_state      <= FLUSH_WB;
                    end else if (w_sc_last) begin
                        flush_done_o <= 1'b1;
                        r_flush_pend <= 1'b0;
                        r_scan       <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_scan <= r_scan + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    if (mem_ack_i) begin
                        r_dirty[w_sc_way][w_sc_set] <= 1'b0;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        // on the last entry, rescan it (now clean) so SCAN ends the flush
                        if (!w_sc_last) r_scan <= r_scan + 1'b1;
                        r_state <= FLUSH_SCAN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // line and tag storage: refill from memory, or word merge on a write hit
    always_ff @(posedge clk_i) begin
        if (w_refill) begin
            r_line[r_victim][w_index] <= mem_data_i;
            r_tag[r_victim][w_index]  <= w_tag;
        end else if (w_wr_hit) begin
            r_line[w_hit_way][w_index][{w_word, 5'b0} +: 32] <= p1_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed checks of dcache_assoc against a set/way array
// model of the cache plus a line-granular memory with a latency-varying responder.
module tb_dcache_assoc;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic         p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_i = '0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         flush_i = 1'b0;
    logic         flush_done_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_assoc #(.ADDR_W(32), .LINE_W(256), .INDEX_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mop_t;

    int n_vec = 0, n_err = 0;
    int n_done = 0;

    // cache model: 32 sets x 2 ways, plus backing memory keyed by line address
    bit           m_valid [32][2];
    bit           m_dirty [32][2];
    logic [21:0]  m_tag   [32][2];
    logic [255:0] m_line  [32][2];
    bit           m_lru   [32];
    logic [255:0] mem_arr [logic [31:0]];
    mop_t         exp_q[$];
    mop_t         log_q[$];

    logic [31:0]  exp_rd = '0;
    bit           exp_on = 1'b0;
    logic [31:0]  last_rd = '0;
    int           lat_tab [4] = '{0, 2, 1, 4};
    int           lat_k = 0;
    int           big_lat = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [255:0] mem_rd(input logic [31:0] la);
        logic [255:0] l;
        if (mem_arr.exists(la)) return mem_arr[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la[15:0] ^ 16'h0040, 16'(i + 1)};
        return l;
    endfunction

    function automatic mop_t log_at(input int i);
        mop_t m;
        m.wr = 1'b0; m.addr = 32'hFFFF_FFFF; m.data = '0;
        if (i < log_q.size()) m = log_q[i];
        return m;
    endfunction

    // returns the word visible at the hit (before any write lands)
    function automatic logic [31:0] model_op(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int idx = int'(a[9:5]);
        int way = -1;
        int v;
        logic [31:0] r;
        mop_t m;
        for (int k = 0; k < 2; k++)
            if (m_valid[idx][k] && m_tag[idx][k] == a[31:10]) way = k;
        if (way < 0) begin
            if (!m_valid[idx][0]) v = 0;
            else if (!m_valid[idx][1]) v = 1;
            else v = int'(m_lru[idx]);
            if (m_valid[idx][v] && m_dirty[idx][v]) begin
                m.wr = 1'b1; m.addr = {m_tag[idx][v], a[9:5], 5'b0}; m.data = m_line[idx][v];
                exp_q.push_back(m);
                mem_arr[m.addr] = m.data;
            end
            m.wr = 1'b0; m.addr = {a[31:5], 5'b0}; m.data = '0;
            exp_q.push_back(m);
            m_line[idx][v]  = mem_rd(m.addr);
            m_valid[idx][v] = 1'b1;
            m_dirty[idx][v] = 1'b0;
            m_tag[idx][v]   = a[31:10];
            way = v;
        end
        r = m_line[idx][way][a[4:2]*32 +: 32];
        if (wr) begin
            m_line[idx][way][a[4:2]*32 +: 32] = d;
            m_dirty[idx][way] = 1'b1;
        end
        m_lru[idx] = (way == 0);
        return r;
    endfunction

    function automatic void model_flush();
        mop_t m;
        logic [4:0] sv;
        for (int s = 0; s < 32; s++) begin
            sv = s[4:0];
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    m.wr = 1'b1; m.addr = {m_tag[s][w], sv, 5'b0}; m.data = m_line[s][w];
                    exp_q.push_back(m);
                    mem_arr[m.addr] = m.data;
                    m_dirty[s][w] = 1'b0;
                end
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 32; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        exp_q.delete();
    endfunction

    // memory responder: checks each request against the model, acks after a varying latency
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && mem_enable_o) begin
                mop_t o, e;
                int lat;
                o.wr = mem_write_o; o.addr = mem_addr_o; o.data = mem_write_o ? mem_data_o : '0;
                log_q.push_back(o);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_unexpected: got wr=%0d addr=%h required no request", o.wr, o.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_write", 256'(o.wr), 256'(e.wr));
                    check("mem_addr", 256'(o.addr), 256'(e.addr));
                    if (e.wr) check("mem_wdata", o.data, e.data);
                end
                lat = (big_lat > 0) ? big_lat : lat_tab[lat_k % 4];
                lat_k++;
                for (int c = 0; c < lat; c++) begin
                    @(negedge clk_i);
                    if (!mem_enable_o || !rst_i) break;
                end
                if (mem_enable_o && rst_i) begin
                    mem_data_i = o.wr ? '0 : mem_rd(o.addr);
                    mem_ack_i  = 1'b1;
                    @(negedge clk_i);
                    mem_ack_i  = 1'b0;
                end
            end
        end
    end

    // CPU-side compare on every cycle a request completes
    always @(negedge clk_i)
        if (rst_i && exp_on && (p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o)
            check("p1_data_o", 256'(p1_data_o), 256'(exp_rd));

    always @(negedge clk_i)
        if (flush_done_o) n_done++;

    task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit with_flush, output int cyc);
        int waited = 0;
        bit done = 1'b0;
        exp_rd = model_op(wr, a, d);
        if (with_flush) model_flush();
        exp_on = 1'b1;
        @(posedge clk_i); #1;
        p1_addr_i = a; p1_data_i = d;
        p1_MemRead_i = !wr; p1_MemWrite_i = wr; flush_i = with_flush;
        while (!done && waited < 500) begin
            @(negedge clk_i);
            waited++;
            if (waited == 2) flush_i = 1'b0;
            if (!p1_stall_o) begin
                done = 1'b1;
                last_rd = p1_data_o;
            end
        end
        if (!done) fail_now("cpu_op_timeout");
        @(posedge clk_i); #1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; flush_i = 1'b0;
        exp_on = 1'b0;
        if (!with_flush) check("mem_outstanding", 256'(exp_q.size()), 256'(0));
        cyc = waited;
    endtask

    task automatic wait_done(input int d0);
        int w = 0;
        while (n_done == d0 && w < 3000) begin
            @(negedge clk_i);
            w++;
        end
        if (n_done == d0) fail_now("flush_done_timeout");
        repeat (3) @(negedge clk_i);
        check("flush_done_pulses", 256'(n_done - d0), 256'(1));
        check("flush_outstanding", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic do_flush(output int nwr);
        int d0 = n_done;
        int l0 = log_q.size();
        model_flush();
        @(posedge clk_i); #1 flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        wait_done(d0);
        nwr = log_q.size() - l0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, l0, nwr, d0, w;
        mop_t m;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_flush_done", 256'(flush_done_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_stall", 256'(p1_stall_o), 256'(0));
        @(posedge clk_i); #1 rst_i = 1'b1;

        // cold read miss
        l0 = log_q.size();
        cpu_op(1'b0, 32'h040, 32'h0, 1'b0, cyc);
        check("cold_rdata", 256'(last_rd), 256'(32'h1));
        check("cold_stalled", 256'(cyc > 1), 256'(1));
        check("cold_nops", 256'(log_q.size() - l0), 256'(1));
        m = log_at(l0);
        check("cold_op", 256'({m.wr, m.addr}), 256'({1'b0, 32'h040}));

        // write hit, then read it back
        l0 = log_q.size();
        cpu_op(1'b1, 32'h044, 32'hDEAD_BEEF, 1'b0, cyc);
        check("wrhit_nostall", 256'(cyc), 256'(1));
        cpu_op(1'b0, 32'h044, 32'h0, 1'b0, cyc);
        check("wrhit_rdata", 256'(last_rd), 256'(32'hDEAD_BEEF));
        check("wrhit_nops", 256'(log_q.size() - l0), 256'(0));

        // second way fill, hit, then LRU eviction of the dirty line
        l0 = log_q.size();
        cpu_op(1'b0, 32'h440, 32'h0, 1'b0, cyc);
        check("way1_nops", 256'(log_q.size() - l0), 256'(1));
        cpu_op(1'b0, 32'h440, 32'h0, 1'b0, cyc);
        check("way1_hit", 256'(cyc), 256'(1));
        l0 = log_q.size();
        cpu_op(1'b0, 32'h840, 32'h0, 1'b0, cyc);
        check("evict_nops", 256'(log_q.size() - l0), 256'(2));
        m = log_at(l0);
        check("evict_wb_op", 256'({m.wr, m.addr}), 256'({1'b1, 32'h040}));
        check("evict_wb_word1", 256'(m.data[63:32]), 256'(32'hDEAD_BEEF));
        m = log_at(l0 + 1);
        check("evict_rd_op", 256'({m.wr, m.addr}), 256'({1'b0, 32'h840}));

        // flush with dirty lines in sets 3 and 7, then an empty flush
        cpu_op(1'b1, 32'h060, 32'h1111_1111, 1'b0, cyc);
        cpu_op(1'b1, 32'h0E4, 32'h2222_2222, 1'b0, cyc);
        l0 = log_q.size();
        do_flush(nwr);
        check("flush1_nwr", 256'(nwr), 256'(2));
        m = log_at(l0);
        check("flush1_first", 256'({m.wr, m.addr}), 256'({1'b1, 32'h060}));
        m = log_at(l0 + 1);
        check("flush1_second", 256'({m.wr, m.addr}), 256'({1'b1, 32'h0E0}));
        do_flush(nwr);
        check("flush2_nwr", 256'(nwr), 256'(0));

        // flush requested together with a read miss: miss first, then flush
        cpu_op(1'b1, 32'h064, 32'h3333_3333, 1'b0, cyc);
        l0 = log_q.size();
        d0 = n_done;
        cpu_op(1'b0, 32'h1040, 32'h0, 1'b1, cyc);
        wait_done(d0);
        m = log_at(l0);
        check("mixflush_miss", 256'({m.wr, m.addr}), 256'({1'b0, 32'h1040}));
        m = log_at(l0 + 1);
        check("mixflush_wb", 256'({m.wr, m.addr}), 256'({1'b1, 32'h060}));

        // reset asserted in the middle of a writeback
        cpu_op(1'b1, 32'h844, 32'h4444_4444, 1'b0, cyc);
        cpu_op(1'b1, 32'h1044, 32'h5555_5555, 1'b0, cyc);
        big_lat = 30;
        exp_rd = model_op(1'b0, 32'h1840, 32'h0);
        @(posedge clk_i); #1;
        p1_addr_i = 32'h1840; p1_MemRead_i = 1'b1;
        w = 0;
        while (!(mem_enable_o && mem_write_o) && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (!(mem_enable_o && mem_write_o)) fail_now("wb_start_timeout");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_mem_enable", 256'(mem_enable_o), 256'(0));
        check("abort_mem_write", 256'(mem_write_o), 256'(0));
        check("abort_mem_addr", 256'(mem_addr_o), 256'(0));
        p1_MemRead_i = 1'b0;
        repeat (3) @(negedge clk_i);
        model_reset();
        big_lat = 0;
        @(posedge clk_i); #1 rst_i = 1'b1;
        l0 = log_q.size();
        cpu_op(1'b0, 32'h040, 32'h0, 1'b0, cyc);
        check("post_rst_miss", 256'(cyc > 1), 256'(1));
        m = log_at(l0);
        check("post_rst_op", 256'({m.wr, m.addr}), 256'({1'b0, 32'h040}));

        repeat (5) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-002 SHALL have parameter LINE_W, 256, line width in bits (power of 2, >=64); OFFSET_W=log2(LINE_W/8).
REQ-003 SHALL have parameter INDEX_W, 5, set-index width; sets=2**INDEX_W; TAG_W=ADDR_W-INDEX_W-OFFSET_W.
REQ-004 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port p1_addr_i  in  ADDR_W  CPU byte address, word-aligned.
REQ-007 SHALL have ports p1_MemRead_i / p1_MemWrite_i  in  1 each  CPU read / write request, mutually exclusive, held stable while p1_stall_o=1.
REQ-008 SHALL have port p1_data_i  in  32  CPU write data.
REQ-009 SHALL have port p1_data_o  out  32  CPU read data.
REQ-010 SHALL have port p1_stall_o  out  1  CPU stall.
REQ-011 SHALL have port flush_i  in  1  single-cycle flush request.
REQ-012 SHALL have port flush_done_o  out  1  one-cycle flush-complete pulse.
REQ-013 SHALL have ports mem_enable_o / mem_write_o  out  1 each  memory request / write.
REQ-014 SHALL have port mem_addr_o  out  ADDR_W  line address, low OFFSET_W bits zero.
REQ-015 SHALL have ports mem_data_o  out  LINE_W and mem_data_i  in  LINE_W  writeback / refill line.
REQ-016 SHALL have port mem_ack_i  in  1  memory done, one cycle, any latency.

Function
REQ-017 SHALL be 2-way set-associative, write-back, write-allocate; per way/set: valid, dirty, tag, line in flops; per set one lru bit naming the least-recently-used way.
REQ-018 SHALL decode offset=addr[OFFSET_W-1:0], index=addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag=upper TAG_W bits.
REQ-019 SHALL assert hit combinationally when either way is valid with matching tag; p1_stall_o = req & (~hit | state!=IDLE).
REQ-020 SHALL drive p1_data_o combinationally with word offset[OFFSET_W-1:2] of the hit line; 0 when no hit.
REQ-021 SHALL, on write hit in IDLE, replace that word at the clock edge and set dirty; other words unchanged.
REQ-022 SHALL, on any hit in IDLE, set lru[index] to the other way.
REQ-023 SHALL use states IDLE, MISS, WRITEBACK, READMISS, REFILL, FLUSH_SCAN, FLUSH_WB.
REQ-024 IDLE: request without hit -> MISS; else pending flush -> FLUSH_SCAN; miss has priority over flush.
REQ-025 MISS: latch victim = first invalid way (way0 first), else lru way; victim dirty -> WRITEBACK with mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line; else -> READMISS with mem_enable_o=1, mem_write_o=0, mem_addr_o={p1 tag,index,0}.
REQ-026 WRITEBACK: on mem_ack_i -> READMISS, mem_write_o=0, mem_addr_o={p1 tag,index,0}, mem_enable_o stays 1.
REQ-027 READMISS: on mem_ack_i write mem_data_i into victim, valid=1, dirty=0, new tag, lru=other way, mem_enable_o=0 -> REFILL.
REQ-028 REFILL -> IDLE unconditionally; request then hits and completes (write merges per REQ-021).
REQ-029 All mem_* outputs SHALL be registered; mem_enable_o deasserts the cycle after the final ack.
REQ-030 flush_i SHALL set a pending flag in any state (repeat pulses while pending ignored).
REQ-031 FLUSH_SCAN SHALL visit (set 0 way0, set 0 way1, set 1 way0 ...); valid&dirty entry -> FLUSH_WB issuing write of that line; else advance one entry per cycle.
REQ-032 FLUSH_WB: on mem_ack_i clear dirty (valid kept), deassert mem_*, return to FLUSH_SCAN at next entry.
REQ-033 After the last entry: pulse flush_done_o one cycle, clear pending, -> IDLE; requests stall throughout flush.

Reset
REQ-034 rst_i low SHALL immediately clear all valid, dirty, lru bits, pending flag, scan pointer, state=IDLE, mem_enable_o=mem_write_o=flush_done_o=0, mem_addr_o=0; mid-transaction aborts with no partial line written.

Verification
REQ-035 Cold read 0x040 -> stall, one read at 0x040; ack line word i=i+1 -> after REFILL p1_data_o=0x00000001, stall drops.
REQ-036 Write 0x044=0xDEADBEEF after REQ-035 -> no memory access, no stall; read 0x044 returns 0xDEADBEEF.
REQ-037 Then read 0x440 (same set, tag 1) -> refill, no writeback; read 0x440 again, then read 0x840 -> writeback at 0x040 containing 0xDEADBEEF in word 1, then read 0x840.
REQ-038 Dirty lines in sets 3 and 7, flush_i -> exactly two writes, set 3 first, one flush_done_o pulse; second flush -> zero writes, one pulse.
REQ-039 flush_i same cycle as read miss -> miss serviced first, then flush, then flush_done_o.
REQ-040 rst_i low during WRITEBACK -> mem_enable_o=0 immediately; after release read 0x040 misses.
